// File: rtl/dma_desc_ctl_if.sv
// Bus bundle for the descriptor controller: wishbone master port plus
// the descriptor handoff channel to the transfer engine.
interface dma_desc_ctl_if;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic        wbm_cab_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;
    logic        wbm_rty_i;

    logic [31:0] desc_addr;
    logic [15:0] desc_len;
    logic [15:0] desc_ctl;
    logic        desc_valid;
    logic        desc_ready;
    logic        desc_done;
    logic [15:0] desc_status;

    modport master (
        output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cab_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i,
        output desc_addr, desc_len, desc_ctl, desc_valid,
        input  desc_ready, desc_done, desc_status
    );

    modport slave (
        input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cab_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i,
        input  desc_addr, desc_len, desc_ctl, desc_valid,
        output desc_ready, desc_done, desc_status
    );
endinterface

// File: rtl/dma_desc_ctl.sv
// Scatter/gather descriptor-chain walker: fetches linked descriptors over
// wishbone, hands each to the transfer engine and writes back its status.
module dma_desc_ctl #(
    parameter int DESC_WORDS = 4
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_n_i,
    input  logic [31:3]   ndar,
    input  logic          ndar_dirty,
    input  logic          enable,
    input  logic          append,
    input  logic          wb_int_clear,
    output logic          ndar_dirty_clear,
    output logic          append_clear,
    output logic [31:0]   dar,
    output logic [7:0]    csr,
    output logic          busy,
    output logic          wb_int_o,
    dma_desc_ctl_if.master bus
);
    localparam logic [1:0]  LAST_BEAT = 2'(DESC_WORDS - 2);
    localparam logic [31:0] WB_OFFS   = 32'((DESC_WORDS - 1) * 4);

    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_ISSUE, ST_WAIT, ST_WBACK, ST_LINK, ST_RELOAD
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] dar_q, dar_d, adr_q, adr_d, dat_q, dat_d, daddr_q, daddr_d;
    logic [31:3] next_q, next_d;
    logic [15:0] len_q, len_d, ctl_q, ctl_d;
    logic [1:0]  beat_q, beat_d;
    logic        cyc_q, cyc_d, stb_q, stb_d, we_q, we_d, cab_q, cab_d;
    logic        eoc_q, eoc_d, valid_q, valid_d, int_q, int_d, err_q, err_d;
    logic        chain_end_q, chain_end_d, busy_q, busy_d;
    logic        dirty_clr_q, dirty_clr_d, app_clr_q, app_clr_d;
    logic        beat_ack;

    assign beat_ack = stb_q && bus.wbm_ack_i && !bus.wbm_err_i;

    always_comb begin
        state_d     = state_q;
        dar_d       = dar_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        daddr_d     = daddr_q;
        next_d      = next_q;
        len_d       = len_q;
        ctl_d       = ctl_q;
        beat_d      = beat_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        cab_d       = cab_q;
        eoc_d       = eoc_q;
        valid_d     = valid_q;
        int_d       = int_q;
        err_d       = err_q;
        chain_end_d = chain_end_q;
        dirty_clr_d = 1'b0;
        app_clr_d   = 1'b0;

        if (wb_int_clear) begin
            int_d = 1'b0;
            err_d = 1'b0;
        end

        // A retried beat sits with stb low for exactly one cycle, then reissues
        if (cyc_q && !stb_q)
            stb_d = 1'b1;

        if (stb_q && bus.wbm_err_i) begin
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            we_d    = 1'b0;
            cab_d   = 1'b0;
            err_d   = 1'b1;
            int_d   = 1'b1;
            state_d = ST_IDLE;
        end else if (stb_q && bus.wbm_rty_i && !bus.wbm_ack_i) begin
            stb_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (enable && ndar_dirty) begin
                    dar_d       = {ndar, 3'b000};
                    adr_d       = {ndar, 3'b000};
                    cyc_d       = 1'b1;
                    stb_d       = 1'b1;
                    we_d        = 1'b0;
                    cab_d       = 1'b1;
                    beat_d      = 2'd0;
                    dirty_clr_d = 1'b1;
                    chain_end_d = 1'b0;
                    state_d     = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (beat_ack) begin
                    case (beat_q)
                        2'd0: begin
                            next_d = bus.wbm_dat_i[31:3];
                            eoc_d  = bus.wbm_dat_i[0];
                        end
                        2'd1:    daddr_d = bus.wbm_dat_i;
                        default: begin
                            len_d = bus.wbm_dat_i[15:0];
                            ctl_d = bus.wbm_dat_i[31:16];
                        end
                    endcase
                    if (beat_q == LAST_BEAT) begin
                        cyc_d   = 1'b0;
                        stb_d   = 1'b0;
                        cab_d   = 1'b0;
                        valid_d = 1'b1;
                        state_d = ST_ISSUE;
                    end else begin
                        beat_d = beat_q + 2'd1;
                        adr_d  = adr_q + 32'd4;
                        cab_d  = (beat_q + 2'd1) != LAST_BEAT;
                    end
                end
            end
            ST_ISSUE: begin
                if (bus.desc_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.desc_done) begin
                    adr_d   = dar_q + WB_OFFS;
                    dat_d   = {bus.desc_status, 15'b0, 1'b1};
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = 1'b1;
                    cab_d   = 1'b0;
                    state_d = ST_WBACK;
                end
            end
            ST_WBACK: begin
                if (beat_ack) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = ST_LINK;
                    if (ctl_q[15])
                        int_d = 1'b1;
                end
            end
            ST_LINK: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (!eoc_q) begin
                    dar_d   = {next_q, 3'b000};
                    adr_d   = {next_q, 3'b000};
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    cab_d   = 1'b1;
                    beat_d  = 2'd0;
                    state_d = ST_FETCH;
                end else if (append) begin
                    app_clr_d = 1'b1;
                    adr_d     = dar_q;
                    cyc_d     = 1'b1;
                    stb_d     = 1'b1;
                    cab_d     = 1'b0;
                    state_d   = ST_RELOAD;
                end else begin
                    chain_end_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_RELOAD: begin
                if (beat_ack) begin
                    next_d = bus.wbm_dat_i[31:3];
                    eoc_d  = bus.wbm_dat_i[0];
                    if (!bus.wbm_dat_i[0]) begin
                        dar_d   = {bus.wbm_dat_i[31:3], 3'b000};
                        adr_d   = {bus.wbm_dat_i[31:3], 3'b000};
                        cab_d   = 1'b1;
                        beat_d  = 2'd0;
                        state_d = ST_FETCH;
                    end else begin
                        cyc_d       = 1'b0;
                        stb_d       = 1'b0;
                        chain_end_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q     <= ST_IDLE;
            dar_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            daddr_q     <= '0;
            next_q      <= '0;
            len_q       <= '0;
            ctl_q       <= '0;
            beat_q      <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            cab_q       <= 1'b0;
            eoc_q       <= 1'b0;
            valid_q     <= 1'b0;
            int_q       <= 1'b0;
            err_q       <= 1'b0;
            chain_end_q <= 1'b0;
            busy_q      <= 1'b0;
            dirty_clr_q <= 1'b0;
            app_clr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dar_q       <= dar_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            daddr_q     <= daddr_d;
            next_q      <= next_d;
            len_q       <= len_d;
            ctl_q       <= ctl_d;
            beat_q      <= beat_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            cab_q       <= cab_d;
            eoc_q       <= eoc_d;
            valid_q     <= valid_d;
            int_q       <= int_d;
            err_q       <= err_d;
            chain_end_q <= chain_end_d;
            busy_q      <= busy_d;
            dirty_clr_q <= dirty_clr_d;
            app_clr_q   <= app_clr_d;
        end
    end

    assign ndar_dirty_clear = dirty_clr_q;
    assign append_clear     = app_clr_q;
    assign dar              = dar_q;
    assign busy             = busy_q;
    assign wb_int_o         = int_q;
    assign csr              = {5'b0, chain_end_q, err_q, busy_q};

    assign bus.wbm_adr_o  = adr_q;
    assign bus.wbm_dat_o  = dat_q;
    assign bus.wbm_sel_o  = 4'hF;
    assign bus.wbm_cyc_o  = cyc_q;
    assign bus.wbm_stb_o  = stb_q;
    assign bus.wbm_we_o   = we_q;
    assign bus.wbm_cab_o  = cab_q;
    assign bus.desc_addr  = daddr_q;
    assign bus.desc_len   = len_q;
    assign bus.desc_ctl   = ctl_q;
    assign bus.desc_valid = valid_q;
endmodule

// File: tb/tb_dma_desc_ctl.sv
// Directed bench for dma_desc_ctl: zero-wait wishbone memory model with
// error/retry injection, table of single-descriptor runs plus chain corner cases.
module tb_dma_desc_ctl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:3] ndar = '0;
    logic        ndar_dirty = 1'b0;
    logic        enable = 1'b0;
    logic        append = 1'b0;
    logic        wb_int_clear = 1'b0;
    logic        ndar_dirty_clear, append_clear, busy, wb_int_o;
    logic [31:0] dar;
    logic [7:0]  csr;
    logic        inj_err = 1'b0;
    logic        inj_rty = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [0:15];
    logic [31:0] rd_log [0:63];
    logic [31:0] wr_adr [0:63];
    logic [31:0] wr_dat [0:63];
    int rd_cnt = 0;
    int wr_cnt = 0;
    int dclr_cnt = 0;
    int aclr_cnt = 0;

    always #5 clk = ~clk;

    dma_desc_ctl_if bus();

    dma_desc_ctl dut (
        .wb_clk_i         (clk),
        .wb_rst_n_i       (rst_n),
        .ndar             (ndar),
        .ndar_dirty       (ndar_dirty),
        .enable           (enable),
        .append           (append),
        .wb_int_clear     (wb_int_clear),
        .ndar_dirty_clear (ndar_dirty_clear),
        .append_clear     (append_clear),
        .dar              (dar),
        .csr              (csr),
        .busy             (busy),
        .wb_int_o         (wb_int_o),
        .bus              (bus)
    );

    function automatic logic [3:0] midx(input logic [31:0] a);
        return {a[13:12], a[3:2]};
    endfunction

    // Zero-wait slave: acks in the same cycle stb is seen unless a fault is injected
    assign bus.wbm_dat_i = mem[midx(bus.wbm_adr_o)];
    assign bus.wbm_ack_i = bus.wbm_cyc_o & bus.wbm_stb_o & ~inj_err & ~inj_rty;
    assign bus.wbm_err_i = bus.wbm_cyc_o & bus.wbm_stb_o & inj_err;
    assign bus.wbm_rty_i = bus.wbm_cyc_o & bus.wbm_stb_o & inj_rty & ~inj_err;

    always @(posedge clk) begin
        if (bus.wbm_cyc_o && bus.wbm_stb_o && bus.wbm_ack_i) begin
            if (bus.wbm_we_o) begin
                wr_adr[wr_cnt[5:0]] <= bus.wbm_adr_o;
                wr_dat[wr_cnt[5:0]] <= bus.wbm_dat_o;
                wr_cnt <= wr_cnt + 1;
            end else begin
                rd_log[rd_cnt[5:0]] <= bus.wbm_adr_o;
                rd_cnt <= rd_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (ndar_dirty_clear) dclr_cnt <= dclr_cnt + 1;
        if (append_clear)     aclr_cnt <= aclr_cnt + 1;
    end

    typedef struct {
        logic [31:0] base;
        logic [31:0] w0, w1, w2;
        logic [15:0] status;
        logic [31:0] exp_wadr, exp_wdat;
        logic        exp_int;
        logic [7:0]  exp_csr;
    } vec_t;

    vec_t vecs [3];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic setDesc(input logic [31:0] base, input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2);
        mem[midx(base)]         = w0;
        mem[midx(base + 32'd4)] = w1;
        mem[midx(base + 32'd8)] = w2;
        mem[midx(base + 32'd12)] = 32'h0;
    endtask

    task automatic clearInt();
        @(negedge clk);
        wb_int_clear = 1'b1;
        @(negedge clk);
        wb_int_clear = 1'b0;
    endtask

    task automatic kick(input logic [31:0] base);
        ndar       = base[31:3];
        ndar_dirty = 1'b1;
        enable     = 1'b1;
        @(negedge clk);
        ndar_dirty = 1'b0;
    endtask

    task automatic waitValid(input int budget);
        int n = 0;
        while (bus.desc_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wait_valid", 32'(bus.desc_valid), 32'd1);
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wait_idle", 32'(busy), 32'd0);
    endtask

    task automatic serveDesc(input logic [15:0] st);
        waitValid(30);
        bus.desc_ready = 1'b1;
        @(negedge clk);
        bus.desc_ready = 1'b0;
        repeat (3) @(negedge clk);
        bus.desc_status = st;
        bus.desc_done   = 1'b1;
        @(negedge clk);
        bus.desc_done   = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        int rb, wb, db;
        clearInt();
        setDesc(v.base, v.w0, v.w1, v.w2);
        rb = rd_cnt;
        wb = wr_cnt;
        db = dclr_cnt;
        kick(v.base);
        checkOutput("dirty_clear", 32'(ndar_dirty_clear), 32'd1);
        checkOutput("first_stb", 32'(bus.wbm_stb_o), 32'd1);
        checkOutput("first_adr", bus.wbm_adr_o, v.base);
        waitValid(20);
        checkOutput("desc_addr", bus.desc_addr, v.w1);
        checkOutput("desc_len", 32'(bus.desc_len), 32'(v.w2[15:0]));
        checkOutput("desc_ctl", 32'(bus.desc_ctl), 32'(v.w2[31:16]));
        checkOutput("rd0", rd_log[rb[5:0]], v.base);
        checkOutput("rd2", rd_log[6'(rb + 2)], v.base + 32'd8);
        bus.desc_ready = 1'b1;
        @(negedge clk);
        bus.desc_ready = 1'b0;
        checkOutput("valid_fall", 32'(bus.desc_valid), 32'd0);
        repeat (5) @(negedge clk);
        bus.desc_status = v.status;
        bus.desc_done   = 1'b1;
        @(negedge clk);
        bus.desc_done   = 1'b0;
        checkOutput("wback_we", 32'(bus.wbm_we_o & bus.wbm_stb_o), 32'd1);
        waitIdle(20);
        checkOutput("wr_count", 32'(wr_cnt - wb), 32'd1);
        checkOutput("wr_adr", wr_adr[wb[5:0]], v.exp_wadr);
        checkOutput("wr_dat", wr_dat[wb[5:0]], v.exp_wdat);
        checkOutput("int", 32'(wb_int_o), 32'(v.exp_int));
        checkOutput("csr", 32'(csr), 32'(v.exp_csr));
        checkOutput("dar", dar, v.base);
        checkOutput("dirty_clear_cnt", 32'(dclr_cnt - db), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int rb, wb, ab, bad, n;

        vecs[0] = '{32'h1000, 32'h1, 32'h8000_0000, 32'h8000_0040, 16'h00AB, 32'h100C, 32'h00AB_0001, 1'b1, 8'h04};
        vecs[1] = '{32'h2000, 32'h1, 32'h9000_0000, 32'h0000_0100, 16'h1234, 32'h200C, 32'h1234_0001, 1'b0, 8'h04};
        vecs[2] = '{32'h3000, 32'h1, 32'hA000_0010, 32'h8001_FFFF, 16'hFFFF, 32'h300C, 32'hFFFF_0001, 1'b1, 8'h04};

        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        bus.desc_ready  = 1'b0;
        bus.desc_done   = 1'b0;
        bus.desc_status = 16'h0;

        repeat (3) @(negedge clk);
        checkOutput("rst_dar", dar, 32'h0);
        checkOutput("rst_csr", 32'(csr), 32'h0);
        checkOutput("rst_ctl", 32'({busy, wb_int_o, bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o,
                                    bus.wbm_cab_o, bus.desc_valid, ndar_dirty_clear, append_clear}), 32'h0);
        checkOutput("rst_adr", bus.wbm_adr_o, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) applyStimulus(vecs[i]);

        // Two-link chain without IRQ
        clearInt();
        setDesc(32'h1000, 32'h2000, 32'h4000_0000, 32'h0000_0010);
        setDesc(32'h2000, 32'h1, 32'h5000_0000, 32'h0000_0020);
        wb = wr_cnt;
        kick(32'h1000);
        serveDesc(16'h0001);
        serveDesc(16'h0002);
        waitIdle(30);
        checkOutput("chain_wr_cnt", 32'(wr_cnt - wb), 32'd2);
        checkOutput("chain_wr0", wr_adr[wb[5:0]], 32'h100C);
        checkOutput("chain_wr1", wr_adr[6'(wb + 1)], 32'h200C);
        checkOutput("chain_dat1", wr_dat[6'(wb + 1)], 32'h0002_0001);
        checkOutput("chain_dar", dar, 32'h2000);
        checkOutput("chain_int", 32'(wb_int_o), 32'd0);
        checkOutput("chain_csr", 32'(csr), 32'h04);

        // Append: end-of-chain descriptor rewritten to link onward while the engine runs
        setDesc(32'h1000, 32'h1, 32'h4000_0000, 32'h0000_0010);
        setDesc(32'h3000, 32'h1, 32'h6000_0000, 32'h0000_0030);
        rb = rd_cnt;
        wb = wr_cnt;
        ab = aclr_cnt;
        append = 1'b1;
        kick(32'h1000);
        waitValid(20);
        bus.desc_ready = 1'b1;
        @(negedge clk);
        bus.desc_ready = 1'b0;
        mem[midx(32'h1000)] = 32'h3000;
        bus.desc_status = 16'h0003;
        bus.desc_done   = 1'b1;
        @(negedge clk);
        bus.desc_done   = 1'b0;
        n = 0;
        while (append_clear !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput("append_clear_seen", 32'(append_clear), 32'd1);
        append = 1'b0;
        serveDesc(16'h0004);
        waitIdle(30);
        checkOutput("append_clr_cnt", 32'(aclr_cnt - ab), 32'd1);
        checkOutput("reload_rd", rd_log[6'(rb + 3)], 32'h1000);
        checkOutput("append_fetch", rd_log[6'(rb + 4)], 32'h3000);
        checkOutput("append_wr1", wr_adr[6'(wb + 1)], 32'h300C);
        checkOutput("append_dar", dar, 32'h3000);
        checkOutput("append_csr", 32'(csr), 32'h04);

        // Bus error on the second fetch beat
        setDesc(32'h1000, 32'h1, 32'h4000_0000, 32'h0000_0010);
        kick(32'h1000);
        @(negedge clk);
        checkOutput("err_beat1_adr", bus.wbm_adr_o, 32'h1004);
        inj_err = 1'b1;
        @(negedge clk);
        inj_err = 1'b0;
        checkOutput("err_cyc", 32'({bus.wbm_cyc_o, bus.wbm_stb_o}), 32'd0);
        checkOutput("err_csr", 32'(csr), 32'h02);
        checkOutput("err_int", 32'(wb_int_o), 32'd1);
        checkOutput("err_dar", dar, 32'h1000);
        clearInt();
        checkOutput("errclr_csr", 32'(csr), 32'h00);
        checkOutput("errclr_int", 32'(wb_int_o), 32'd0);

        // Stalled handoff, then a retried write-back
        setDesc(32'h1000, 32'h1, 32'h7000_0000, 32'h8000_0020);
        wb = wr_cnt;
        kick(32'h1000);
        waitValid(20);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.desc_valid !== 1'b1 || bus.desc_addr !== 32'h7000_0000 ||
                bus.desc_len !== 16'h0020 || bus.desc_ctl !== 16'h8000) bad++;
        end
        checkOutput("hold_stable", 32'(bad), 32'd0);
        bus.desc_ready = 1'b1;
        @(negedge clk);
        bus.desc_ready = 1'b0;
        repeat (2) @(negedge clk);
        bus.desc_status = 16'h0055;
        bus.desc_done   = 1'b1;
        @(negedge clk);
        bus.desc_done   = 1'b0;
        checkOutput("rty_first_adr", bus.wbm_adr_o, 32'h100C);
        inj_rty = 1'b1;
        @(negedge clk);
        inj_rty = 1'b0;
        checkOutput("rty_gap", 32'({bus.wbm_cyc_o, bus.wbm_stb_o}), 32'b10);
        @(negedge clk);
        checkOutput("rty_reissue_stb", 32'(bus.wbm_stb_o), 32'd1);
        checkOutput("rty_reissue_adr", bus.wbm_adr_o, 32'h100C);
        checkOutput("rty_reissue_dat", bus.wbm_dat_o, 32'h0055_0001);
        waitIdle(20);
        checkOutput("rty_wr_cnt", 32'(wr_cnt - wb), 32'd1);
        checkOutput("rty_int", 32'(wb_int_o), 32'd1);

        // Asynchronous reset in the middle of a fetch burst
        clearInt();
        setDesc(32'h1000, 32'h1, 32'h4000_0000, 32'h0000_0010);
        kick(32'h1000);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_bus", 32'({bus.wbm_cyc_o, bus.wbm_stb_o, busy}), 32'd0);
        checkOutput("arst_dar", dar, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dma_desc_ctl.md
# dma_desc_ctl

Descriptor-chain controller for the scatter/gather DMA channel. It sits directly downstream of the wishbone register slave. It consumes `ndar`/`ndar_dirty`/`enable`/`append` and returns `dar`, `busy`, `wb_int_o`, `csr` and the one-cycle clear strobes. It walks a linked list of 16-byte descriptors in system memory over a wishbone master port. Each descriptor is handed to the transfer engine through a valid/ready handshake, and a done/status word is written back before the link is followed.

## Interface
- `DESC_WORDS`, 4, words per descriptor fetched (word0 next, word1 buffer addr, word2 control, word3 status)
- `wb_clk_i` in 1 — single clock for all logic
- `wb_rst_n_i` in 1 — asynchronous, active-low reset
- `ndar` in [31:3] — next-descriptor address from the register slave
- `ndar_dirty`, `enable`, `append`, `wb_int_clear` in 1 — controls from the register slave
- `ndar_dirty_clear`, `append_clear` out 1 — one-cycle acknowledge strobes
- `dar` out 32 — address of the current descriptor
- `csr` out 8 — bit0 busy, bit1 bus_err (sticky), bit2 chain_end; others 0
- `busy`, `wb_int_o` out 1 — controller active; interrupt request
- `wbm_adr_o` out 32, `wbm_dat_o` out 32, `wbm_sel_o` out 4 — master address, write data, byte selects (`wbm_sel_o` constant 4'hF)
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o`, `wbm_cab_o` out 1 — master cycle controls
- `wbm_dat_i` in 32; `wbm_ack_i`, `wbm_err_i`, `wbm_rty_i` in 1 — master read data and responses
- `desc_addr` out 32 — word1 of the current descriptor
- `desc_len` out 16 — word2[15:0]
- `desc_ctl` out 16 — word2[31:16]; bit15 = IRQ-on-complete
- `desc_valid` out 1, `desc_ready` in 1 — descriptor handoff to the transfer engine
- `desc_done` in 1, `desc_status` in 16 — engine completion pulse and result

## Operation
- States: IDLE, FETCH, ISSUE, WAIT, WBACK, LINK, RELOAD.
- IDLE:
  - Leaves IDLE only when `enable && ndar_dirty`.
  - On leaving, latches `dar <= {ndar,3'b000}`, pulses `ndar_dirty_clear` for 1 cycle, and goes to FETCH.
- FETCH:
  - Reads words 0..2 at `dar+0`, `+4`, `+8`.
  - `wbm_cyc_o` is held for the whole burst.
  - `wbm_cab_o` is 1 except on the last beat.
  - The address advances by 4 on each `wbm_ack_i`.
  - Word0 is stored as next[31:3] plus eoc = bit0.
  - After the third ack, goes to ISSUE.
- ISSUE: `desc_valid=1` until `desc_ready` is sampled high, then WAIT. Descriptor outputs are stable while valid.
- WAIT: on `desc_done`, captures `desc_status` and goes to WBACK.
- WBACK: single write of `{desc_status,15'b0,1'b1}` to `dar+12`, with `wbm_we_o=1`. On ack, goes to LINK.
- LINK:
  - If desc_ctl[15], sets `wb_int_o`.
  - If `!enable`: go to IDLE.
  - Else if eoc=0: `dar <= {next,3'b000}`, go to FETCH.
  - Else if `append`: pulse `append_clear`, go to RELOAD.
  - Else: set chain_end, go to IDLE.
- RELOAD:
  - Single read of word0 at `dar`.
  - If the new eoc=0, follow the link as in LINK.
  - Otherwise set chain_end and go to IDLE.
- `wbm_rty_i`: drop stb for 1 cycle, then reissue the same beat (same address and data).
- `wbm_err_i` in any bus state:
  - Terminate the cycle and set `csr[1]` and `wb_int_o`.
  - Go to IDLE; `dar` holds the faulting descriptor.
- `wb_int_clear` clears `wb_int_o` and `csr[1]`. A set in the same cycle wins.
- chain_end clears on the next exit from IDLE.
- `busy = (state != IDLE)`; `csr[0]=busy`.
- `ndar_dirty` asserted while not IDLE is ignored until the controller returns to IDLE.
- Reset: state IDLE. Every output is 0, including `dar`, `csr`, `wbm_*` controls, `desc_valid`, `wb_int_o` and the strobes.

## Timing
- All outputs are registered.
- IDLE→first `wbm_stb_o` = 1 cycle after `ndar_dirty` is sampled.
- Bus beats:
  - One beat completes per ack; stb may stay high back-to-back.
  - Zero-wait slave: 3-word fetch in 3 cycles after stb rise.
- ISSUE:
  - `desc_valid` rises 1 cycle after the last fetch ack.
  - It falls in the cycle after `desc_ready` is sampled.
- WBACK write is issued 1 cycle after `desc_done`.
- `wb_int_o` rises 1 cycle after the WBACK ack.
- `desc_done` must only arrive in WAIT; pulses in other states are ignored.
- Asynchronous reset mid-burst drops `wbm_cyc_o`/`wbm_stb_o` immediately.

## Test plan
- Single descriptor (eoc=1, IRQ):
  - Stimulus: `ndar`=0x1000, dirty, enable; zero-wait memory; engine done after 5 cycles with status 0x00AB.
  - Reads at 0x1000/4/8 and `ndar_dirty_clear` for 1 cycle.
  - Write 0x00AB0001 to 0x100C, `wb_int_o`=1, `csr`=0x04, then IDLE.
- Two-link chain (0x1000→0x2000, second eoc=1, no IRQ): two write-backs, `dar`=0x2000 at end, `wb_int_o` stays 0.
- Append:
  - Stimulus: eoc=1 with `append`=1; memory word0 rewritten to 0x3000.
  - `append_clear` pulses for 1 cycle, RELOAD reads 0x1000, then fetch at 0x3000.
- `wbm_err_i` on the second fetch beat: cycle ends, `csr[1]`=1, `wb_int_o`=1, IDLE with `dar`=0x1000. `wb_int_clear` then zeros both.
- Handshake and retry:
  - `desc_ready` is held low for 10 cycles: `desc_valid` and descriptor outputs stay constant.
  - A `wbm_rty_i` on WBACK reissues the identical write.
- Reset asserted during FETCH: all outputs go to 0 asynchronously. After release, a new `ndar_dirty` restarts cleanly.
